uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter for the UART link; it is the stage directly upstream of the UART receiver on the serial wire.
- Accepts a parallel word through a valid/ready handshake.
- Emits one frame per word: start bit, VLD_DATA_WIDTH data bits LSB first, one parity bit, STOP_BITS stop bits.
- Frame format and parameters match the receiver, so TX can be looped straight into its RX input.

Parameters:
BAUD_RATE, 115200, line bit rate in bit/s.
CLK_FREQ, 10_000_000, CLK frequency in Hz.
VLD_DATA_WIDTH, 8, data bits per frame.
CHECK_SEL, 1, parity select: 1 = odd (total ones in data+parity is odd), 0 = even.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
CLK  input  1  system clock, rising-edge.
rst_n  input  1  reset, synchronous, active-low.
din  input  VLD_DATA_WIDTH  word to transmit.
din_vld  input  1  din valid.
din_rdy  output  1  transmitter can accept a word.
TX  output  1  serial line, idle high.
tx_busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Single clock CLK; rst_n is synchronous, active-low.
- Bit period: BAUD_DIV = CLK_FREQ/BAUD_RATE, integer truncation (86 at the defaults). Every bit lasts exactly BAUD_DIV cycles.
- Reset values: TX=1, din_rdy=0 while rst_n=0, tx_busy=0, tx_done=0, state IDLE, counters 0. din_rdy rises the first cycle after rst_n=1 is sampled.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - TX=1, din_rdy=1, tx_busy=0.
  - Handshake din_vld&din_rdy at edge N: din and its parity bit are captured into a shift register; state goes to START.
  - From cycle N+1: TX=0, din_rdy=0, tx_busy=1.
- START: TX=0 for BAUD_DIV cycles, then DATA.
- DATA:
  - TX = shift_reg[0]; shift right at each bit boundary.
  - Bit counter counts 0..VLD_DATA_WIDTH-1; after the last data bit, go to PARITY.
- PARITY: TX = ^data XOR CHECK_SEL inverted, i.e. odd: ~^data, even: ^data. Lasts BAUD_DIV cycles, then STOP.
- STOP:
  - TX=1 for STOP_BITS*BAUD_DIV cycles.
  - tx_done=1 on the final cycle; next state IDLE.
- Latency:
  - Handshake edge to TX falling edge: 1 cycle.
  - Frame length: (2+VLD_DATA_WIDTH+STOP_BITS)*BAUD_DIV cycles, i.e. 946 at the defaults.
  - Back-to-back: din_rdy is high on the cycle after tx_done. If din_vld is held high, the inter-frame gap is exactly 1 IDLE cycle (TX=1).
- While busy: din and din_vld are ignored. The captured word never changes mid-frame.
- Baud counter: counts 0..BAUD_DIV-1 and wraps. It is cleared on handshake so the start bit is a full BAUD_DIV cycles.
- Reset mid-frame: at the next edge with rst_n=0, TX=1 and state IDLE. The partial frame is abandoned, tx_done is not pulsed, and the word is lost.
- din_vld asserted during reset: not accepted, because din_rdy=0.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - function baud_div(CLK_FREQ, BAUD_RATE);
  - localparam parity constants ODD=1, EVEN=0, shared with the receiver.
- One sub-module, uart_baud_gen: a counter with clear input that outputs a bit_tick pulse every BAUD_DIV cycles. It is reusable by the receiver (mid-bit variant).

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with din_vld=1 -> TX=1, din_rdy=0, tx_busy=0 throughout; din_rdy=1 exactly 1 cycle after rst_n=1; nothing transmitted.
- Single frame din=8'h16, CHECK_SEL=1, sampled mid-bit -> TX sequence 0,0,1,1,0,1,0,0,0,0(parity),1; each bit lasts 86 cycles; tx_done pulses once, 946 cycles after the TX falling edge.
- Parity sweep CHECK_SEL=1 -> parity bit 1 for 8'hAF, 0 for 8'h32, 1 for 8'h00, 1 for 8'hFF. Repeat with CHECK_SEL=0 -> every value inverted.
- Back-to-back: din_vld held high with 8'h16, 8'h32, 8'hAF -> exactly one idle cycle between frames. Loopback into the receiver gives dout 8'h16, 8'h32, 8'hAF with RX_dout_vld and error=0.
- Busy ignore: change din to 8'h55 while din_vld=1 during DATA of 8'h16 -> the frame still carries 8'h16; 8'h55 is accepted only after tx_done.
- Reset mid-frame: drive rst_n=0 during the 4th data bit -> TX=1 next edge, no tx_done. The next accepted word 8'hA5 transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers, common to the transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic ODD  = 1'b1;
    localparam logic EVEN = 1'b0;

    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and wraps; clr restarts the period at 0.
// pre_tick leads bit_tick by one cycle so callers can register end-of-bit outputs.
module uart_baud_gen #(
    parameter int DIV = 86
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick,
    output logic pre_tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick = (cnt_q == CW'(DIV - 1));
    assign pre_tick = (cnt_q == CW'(DIV - 2));
    assign cnt_d    = bit_tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge CLK) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, one parity bit, STOP_BITS stop bits.
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), tx_done on the last cycle
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE      = 115200,
    parameter int CLK_FREQ       = 10_000_000,
    parameter int VLD_DATA_WIDTH = 8,
    parameter int CHECK_SEL      = 1,
    parameter int STOP_BITS      = 1
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic [VLD_DATA_WIDTH-1:0] din,
    input  logic                      din_vld,
    output logic                      din_rdy,
    output logic                      TX,
    output logic                      tx_busy,
    output logic                      tx_done
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int BCW      = (VLD_DATA_WIDTH > 1) ? $clog2(VLD_DATA_WIDTH) : 1;
    localparam int SCW      = 1;

    tx_state_t                 state_q;
    logic [VLD_DATA_WIDTH:0]   shift_q;
    logic [BCW-1:0]            bit_cnt_q;
    logic [SCW-1:0]            stop_cnt_q;
    logic                      tx_q;
    logic                      rdy_q;
    logic                      busy_q;
    logic                      done_q;

    logic par_d;
    logic accept;
    logic bit_tick;
    logic pre_tick;
    logic last_stop;

    assign par_d     = (CHECK_SEL == int'(ODD)) ? ~^din : ^din;
    assign accept    = din_vld & rdy_q;
    assign last_stop = (stop_cnt_q == SCW'(STOP_BITS - 1));

    uart_baud_gen #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .clr     (accept),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    // The parity bit rides above the data in the shift register, so it
    // reaches bit 1 exactly when the last data bit is on the line.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        shift_q <= {par_d, din};
                        state_q <= START;
                        tx_q    <= 1'b0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        if (bit_cnt_q == BCW'(VLD_DATA_WIDTH - 1)) begin
                            state_q <= PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state_q    <= STOP;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= '0;
                    end
                end
                STOP: begin
                    if (pre_tick && last_stop) begin
                        done_q <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (last_stop) begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + SCW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TX      = tx_q;
    assign din_rdy = rdy_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + random bench for uart_tx; odd- and even-parity instances share stimulus.
module tb_uart_tx;
    localparam int W     = 8;
    localparam int DIV   = 10_000_000 / 115200;
    localparam int NBITS = 2 + W + 1;
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_vld;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx #(.CHECK_SEL(1)) dut_odd (
        .CLK(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .din_rdy(rdy_a), .TX(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(.CHECK_SEL(0)) dut_even (
        .CLK(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .din_rdy(rdy_b), .TX(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame, index 0 = first bit on the line.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit odd);
        logic p;
        if (odd) p = (($countones(d) % 2) == 0);
        else     p = (($countones(d) % 2) == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [7:0] outs();
        return {tx_a, rdy_a, busy_a, done_a, tx_b, rdy_b, busy_b, done_b};
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] d, input bit keep_vld);
        int w;
        w = 0;
        din     = d;
        din_vld = 1'b1;
        while (rdy_a !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", {31'b0, rdy_a}, 1);
        @(negedge clk);
        if (!keep_vld) din_vld = 1'b0;
    endtask

    // Checks one whole frame from its first low cycle; returns at the negedge of the last cycle.
    task automatic check_frame(input logic [7:0] d, input int max_wait, input int act_k,
                               input logic [7:0] act_din, input logic act_vld,
                               output logic par_a, output logic par_b);
        logic [10:0] exp_a, exp_b, got_a, got_b;
        int w, bad_a, bad_b, bad_ctl, ndone, done_k;
        exp_a = frame_bits(d, 1'b1);
        exp_b = frame_bits(d, 1'b0);
        got_a = '0; got_b = '0;
        w = 0; bad_a = 0; bad_b = 0; bad_ctl = 0; ndone = 0; done_k = -1;
        while (tx_a !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("frame_start", {31'b0, tx_a}, 0);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (k == act_k) begin
                din     = act_din;
                din_vld = act_vld;
            end
            if (tx_a !== exp_a[k / DIV]) bad_a++;
            if (tx_b !== exp_b[k / DIV]) bad_b++;
            if (busy_a !== 1'b1 || busy_b !== 1'b1 || rdy_a !== 1'b0 || rdy_b !== 1'b0) bad_ctl++;
            if (done_b !== done_a) bad_ctl++;
            if (done_a === 1'b1) begin
                ndone++;
                done_k = k;
            end
            if (k % DIV == DIV / 2) begin
                got_a[k / DIV] = tx_a;
                got_b[k / DIV] = tx_b;
            end
        end
        chk("data_odd", {24'b0, got_a[8:1]}, {24'b0, d});
        chk("data_even", {24'b0, got_b[8:1]}, {24'b0, d});
        chk("parity_odd", {31'b0, got_a[9]}, {31'b0, exp_a[9]});
        chk("parity_even", {31'b0, got_b[9]}, {31'b0, exp_b[9]});
        chk("tx_odd_cycles", bad_a, 0);
        chk("tx_even_cycles", bad_b, 0);
        chk("busy_rdy_in_frame", bad_ctl, 0);
        chk("done_count", ndone, 1);
        chk("frame_len", done_k + 1, FRAME);
        par_a = got_a[9];
        par_b = got_b[9];
    endtask

    initial begin
        logic       pa, pb;
        logic [7:0] d;
        logic [7:0] sweep [4];
        logic       sweep_odd [4];
        int         nd;
        sweep     = '{8'hAF, 8'h32, 8'h00, 8'hFF};
        sweep_odd = '{1'b1, 1'b0, 1'b1, 1'b1};

        rst_n   = 1'b0;
        din_vld = 1'b1;
        din     = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_outputs", {24'b0, outs()}, 32'h88);
        end
        rst_n   = 1'b1;
        din_vld = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", {24'b0, outs()}, 32'hCC);
        repeat (3) begin
            @(negedge clk);
            chk("idle_line", {24'b0, outs()}, 32'hCC);
        end

        send(8'h16, 1'b0);
        check_frame(8'h16, 0, -1, 8'h00, 1'b0, pa, pb);
        chk("par_16_odd", {31'b0, pa}, 0);
        @(negedge clk);
        chk("idle_after_16", {24'b0, outs()}, 32'hCC);

        for (int i = 0; i < 4; i++) begin
            send(sweep[i], 1'b0);
            check_frame(sweep[i], 0, -1, 8'h00, 1'b0, pa, pb);
            chk("sweep_odd", {31'b0, pa}, {31'b0, sweep_odd[i]});
            chk("sweep_even", {31'b0, pb}, {31'b0, ~sweep_odd[i]});
            @(negedge clk);
        end

        send(8'h16, 1'b1);
        check_frame(8'h16, 0, 1, 8'h32, 1'b1, pa, pb);
        @(negedge clk);
        chk("b2b_gap1", {24'b0, outs()}, 32'hCC);
        @(negedge clk);
        check_frame(8'h32, 0, 1, 8'hAF, 1'b1, pa, pb);
        @(negedge clk);
        chk("b2b_gap2", {24'b0, outs()}, 32'hCC);
        @(negedge clk);
        check_frame(8'hAF, 0, 1, 8'h00, 1'b0, pa, pb);
        @(negedge clk);
        chk("b2b_end", {24'b0, outs()}, 32'hCC);

        send(8'h16, 1'b1);
        check_frame(8'h16, 0, 300, 8'h55, 1'b1, pa, pb);
        @(negedge clk);
        chk("busy_gap", {24'b0, outs()}, 32'hCC);
        @(negedge clk);
        check_frame(8'h55, 0, 1, 8'h00, 1'b0, pa, pb);
        @(negedge clk);

        send(8'h16, 1'b0);
        nd = 0;
        for (int k = 1; k <= 4 * DIV + 40; k++) begin
            @(negedge clk);
            if (done_a === 1'b1 || done_b === 1'b1) nd++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {24'b0, outs()}, 32'h88);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * DIV; k++) begin
            @(negedge clk);
            if (done_a === 1'b1 || done_b === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_idle", {24'b0, outs()}, 32'hCC);
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 0, -1, 8'h00, 1'b0, pa, pb);
        @(negedge clk);

        repeat (4) begin
            d = 8'($urandom);
            send(d, 1'b0);
            check_frame(d, 0, -1, 8'h00, 1'b0, pa, pb);
            @(negedge clk);
            chk("rand_idle", {24'b0, outs()}, 32'hCC);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
